// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared types, sizing helpers and quarter-wave ROM contents
package sine_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Peak magnitude of a signed sample
  function automatic int amplitude(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Midscale code added to turn a signed sample into offset binary
  function automatic int offset(input int dw);
    return 1 << (dw - 1);
  endfunction

  // round(A*sin(2*pi*k/2^aw)) for k in the first quadrant, via a Taylor series
  function automatic int quarter_sine(input int k, input int aw, input int dw);
    real x;
    real term;
    real acc;
    x    = 2.0 * 3.141592653589793 * real'(k) / real'(1 << aw);
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return $rtoi(real'(amplitude(dw)) * acc + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - quarter-wave sine ROM with quadrant folding, 1-cycle latency
module sine_quarter_lut
  import sine_pkg::*;
#(
  parameter int LUT_AW     = 10,
  parameter int DATA_W     = 12,
  parameter int SIGNED_OUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] idx,
  output logic [DATA_W-1:0] sample
);

  localparam int QW = LUT_AW - 2;
  localparam int QN = 1 << QW;

  logic [DATA_W-2:0] rom [QN];

  for (genvar k = 0; k < QN; k++) begin : g_rom
    assign rom[k] = (DATA_W-1)'(quarter_sine(k, LUT_AW, DATA_W));
  end

  logic [1:0]        quad;
  logic [QW-1:0]     off;
  logic [QW-1:0]     addr;
  logic              peak;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] folded;

  // Fold the full-wave index onto the quarter ROM; the exact crest of quadrants 1/3
  // lies one entry beyond the table and is supplied as the amplitude constant.
  always_comb begin
    quad   = idx[LUT_AW-1:LUT_AW-2];
    off    = idx[QW-1:0];
    addr   = quad[0] ? (QW'(0) - off) : off;
    peak   = quad[0] && (off == '0);
    mag    = peak ? DATA_W'(amplitude(DATA_W)) : {1'b0, rom[addr]};
    folded = quad[1] ? (DATA_W'(0) - mag) : mag;
    if (SIGNED_OUT == 0) folded = folded + DATA_W'(offset(DATA_W));
  end

  // Registered read stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sample <= '0;
    else      sample <= folded;
  end

endmodule

// File: rtl/sine_sum_multi.sv
// rtl/sine_sum_multi.sv - N-channel DDS summer sharing one time-multiplexed sine LUT
module sine_sum_multi
  import sine_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int PHASE_W    = 12,
  parameter int LUT_AW     = 10,
  parameter int DATA_W     = 12,
  parameter int SIGNED_OUT = 0,
  localparam int SUM_W     = DATA_W + ((clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_en,
  input  logic [NUM_CH*PHASE_W-1:0] delta,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      ovr_clr,
  output logic [SUM_W-1:0]          sind_sum,
  output logic                      sum_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CH_W = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [PHASE_W-1:0] phase     [NUM_CH];
  logic [PHASE_W-1:0] delta_lat [NUM_CH];
  logic [NUM_CH-1:0]  en_lat;
  logic [SUM_W-1:0]   acc;
  logic               rd_pend;
  logic               rd_on;
  logic [LUT_AW-1:0]  lut_idx;
  logic [DATA_W-1:0]  lut_sample;
  logic [SUM_W-1:0]   sample_ext;

  // LUT address from the current channel's pre-increment phase; sample widened for the sum
  always_comb begin
    lut_idx    = phase[ch][PHASE_W-1 -: LUT_AW];
    sample_ext = (SIGNED_OUT != 0)
               ? {{(SUM_W-DATA_W){lut_sample[DATA_W-1]}}, lut_sample}
               : {{(SUM_W-DATA_W){1'b0}}, lut_sample};
  end

  sine_quarter_lut #(
    .LUT_AW    (LUT_AW),
    .DATA_W    (DATA_W),
    .SIGNED_OUT(SIGNED_OUT)
  ) u_lut (
    .clk   (clk),
    .rst   (rst),
    .idx   (lut_idx),
    .sample(lut_sample)
  );

  // Round sequencer: latch, issue one channel per cycle, drain the LUT, publish the sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      en_lat    <= '0;
      acc       <= '0;
      rd_pend   <= 1'b0;
      rd_on     <= 1'b0;
      sind_sum  <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase[i]     <= '0;
        delta_lat[i] <= '0;
      end
    end else begin
      sum_valid <= 1'b0;
      // A read issued in RUN lands one cycle later and is folded into acc then
      rd_pend   <= (state == S_RUN);
      rd_on     <= en_lat[ch];
      if (rd_pend && rd_on) acc <= acc + sample_ext;
      if (sample_en && busy) overrun <= 1'b1;
      else if (ovr_clr)      overrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_en) begin
            for (int i = 0; i < NUM_CH; i++) delta_lat[i] <= delta[i*PHASE_W +: PHASE_W];
            en_lat <= ch_en;
            acc    <= '0;
            ch     <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (en_lat[ch]) phase[ch] <= phase[ch] + delta_lat[ch];
          if (ch == CH_W'(NUM_CH - 1)) state <= S_DRAIN;
          else                         ch    <= ch + 1'b1;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          sind_sum  <= acc;
          sum_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_sum_multi.sv
// tb/tb_sine_sum_multi.sv - randomized self-checking bench against a behavioural DDS model
module tb_sine_sum_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [23:0] delta;
  logic [1:0]  ch_en;
  logic        ovr_clr;
  logic [12:0] sum_u, sum_s;
  logic        valid_u, valid_s, busy_u, busy_s, ovr_u, ovr_s;

  int n_checks = 0;
  int n_errors = 0;
  int ph [2];

  always #5 clk = ~clk;

  sine_sum_multi #(.NUM_CH(2), .PHASE_W(12), .LUT_AW(10), .DATA_W(12), .SIGNED_OUT(0)) dut_u (
    .clk(clk), .rst(rst), .sample_en(sample_en), .delta(delta), .ch_en(ch_en),
    .ovr_clr(ovr_clr), .sind_sum(sum_u), .sum_valid(valid_u), .busy(busy_u), .overrun(ovr_u)
  );

  sine_sum_multi #(.NUM_CH(2), .PHASE_W(12), .LUT_AW(10), .DATA_W(12), .SIGNED_OUT(1)) dut_s (
    .clk(clk), .rst(rst), .sample_en(sample_en), .delta(delta), .ch_en(ch_en),
    .ovr_clr(ovr_clr), .sind_sum(sum_s), .sum_valid(valid_s), .busy(busy_s), .overrun(ovr_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sine_ref(input int idx);
    real x;
    x = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 1024.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // One round of the model: pre-increment phases feed the sum, enabled phases advance
  task automatic model_round(input logic [23:0] d, input logic [1:0] en,
                             output int eu, output int es);
    int s;
    eu = 0;
    es = 0;
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        s     = sine_ref(ph[i] >> 2);
        eu   += s + 2048;
        es   += s;
        ph[i] = (ph[i] + int'(d[i*12 +: 12])) % 4096;
      end
    end
  endtask

  task automatic run_round(input logic [23:0] d, input logic [1:0] en, input bit mid,
                           input logic [23:0] d2, input logic [1:0] en2,
                           output int got_u, output int got_s);
    int eu, es, vcyc, bcnt;
    model_round(d, en, eu, es);
    @(negedge clk);
    sample_en = 1'b1;
    delta     = d;
    ch_en     = en;
    @(posedge clk);
    @(negedge clk);
    sample_en = 1'b0;
    if (mid) begin
      delta = d2;
      ch_en = en2;
    end
    vcyc  = 0;
    bcnt  = 0;
    got_u = -99999;
    got_s = -99999;
    for (int n = 1; n <= 12 && vcyc == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy_u) bcnt++;
      if (valid_u) begin
        vcyc  = n;
        got_u = int'(sum_u);
        got_s = int'($signed(sum_s));
        check("sum_unsigned", got_u, eu);
        check("sum_signed", got_s, es);
        check("valid_signed_dut", int'(valid_s), 1);
      end
    end
    check("valid_latency", vcyc, 5);
    check("busy_cycles", bcnt, 4);
    @(negedge clk);
    check("valid_one_cycle", int'(valid_u), 0);
  endtask

  initial begin
    int gu, gs, npulse, vseen, eu, es;
    logic [23:0] d, d2;
    logic [1:0]  en, en2;
    bit          mid;
    int tbl_u [5] = '{2048, 4095, 2048, 1, 2048};
    int tbl_s [5] = '{0, 2047, 0, -2047, 0};

    rst = 1'b0; sample_en = 1'b0; delta = '0; ch_en = '0; ovr_clr = 1'b0;
    ph[0] = 0; ph[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_sum_u", int'(sum_u), 0);
    check("rst_sum_s", int'(sum_s), 0);
    check("rst_valid", int'(valid_u), 0);
    check("rst_busy", int'(busy_u), 0);
    check("rst_overrun", int'(ovr_u), 0);
    rst = 1'b1;
    @(negedge clk);

    // delta 0, both channels: midscale twice
    run_round(24'd0, 2'b11, 1'b0, 24'd0, 2'b00, gu, gs);
    check("first_round_u", gu, 4096);
    check("first_round_s", gs, 0);

    // Channel 0 stepping a quarter turn per round, channel 1 off
    for (int k = 0; k < 5; k++) begin
      run_round({12'd0, 12'd1024}, 2'b01, 1'b0, 24'd0, 2'b00, gu, gs);
      check("quarter_seq_u", gu, tbl_u[k]);
      check("quarter_seq_s", gs, tbl_s[k]);
    end

    // Mid-RUN changes take effect next round; disabled channel's phase holds
    run_round({12'd300, 12'd1024}, 2'b11, 1'b1, {12'd777, 12'd512}, 2'b01, gu, gs);
    run_round({12'd777, 12'd512}, 2'b01, 1'b0, 24'd0, 2'b00, gu, gs);
    run_round({12'd777, 12'd512}, 2'b11, 1'b0, 24'd0, 2'b00, gu, gs);

    // Randomized rounds with occasional mid-round input changes
    d  = 24'($urandom);
    en = 2'($urandom);
    for (int k = 0; k < 24; k++) begin
      mid = 1'($urandom);
      d2  = 24'($urandom);
      en2 = 2'($urandom);
      run_round(d, en, mid, d2, en2, gu, gs);
      d  = mid ? d2  : 24'($urandom);
      en = mid ? en2 : 2'($urandom);
    end

    // sample_en held high: round every 5 cycles, overrun set, set beats clear
    model_round(24'd0, 2'b11, eu, es);
    @(negedge clk);
    sample_en = 1'b1;
    delta     = 24'd0;
    ch_en     = 2'b11;
    @(posedge clk);
    npulse = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      ovr_clr = (n == 3);
      if (n == 2) check("overrun_set", int'(ovr_u), 1);
      if (n == 4) check("overrun_set_wins", int'(ovr_u), 1);
      if (valid_u) begin
        npulse++;
        check("continuous_spacing", n % 5, 0);
        check("continuous_sum_u", int'(sum_u), eu);
        check("continuous_sum_s", int'($signed(sum_s)), es);
      end
    end
    check("continuous_pulses", npulse, 4);
    sample_en = 1'b0;
    repeat (8) @(negedge clk);
    check("overrun_sticky", int'(ovr_s), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("overrun_clear_u", int'(ovr_u), 0);
    check("overrun_clear_s", int'(ovr_s), 0);

    // Reset mid-RUN aborts the round and restarts phases from zero
    @(negedge clk);
    sample_en = 1'b1;
    delta     = {12'd100, 12'd200};
    ch_en     = 2'b11;
    @(posedge clk);
    @(negedge clk);
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_sum_u", int'(sum_u), 0);
    check("midrst_sum_s", int'(sum_s), 0);
    check("midrst_busy", int'(busy_u), 0);
    check("midrst_valid", int'(valid_u), 0);
    @(negedge clk);
    rst = 1'b1;
    vseen = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_u || valid_s) vseen++;
    end
    check("no_valid_after_rst", vseen, 0);
    ph[0] = 0; ph[1] = 0;
    run_round(24'd0, 2'b11, 1'b0, 24'd0, 2'b00, gu, gs);
    check("post_rst_round_u", gu, 4096);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sine_sum_multi.md
Name: sine_sum_multi

Overview:
- Parametrised successor to the two-tone unsigned sine summer: N DDS channels, each with its own phase accumulator and phase increment.
- All channels share one quarter-wave sine LUT, time-multiplexed one channel per clock; a round is started by a sample strobe.
- Per-channel samples are summed into a single composite output, with unsigned or signed output mode.
- Sits between the sample-rate tick generator and the downstream DAC/filter chain.

Parameters:
- NUM_CH, 2, number of sine channels (1..16).
- PHASE_W, 12, phase accumulator and increment width.
- LUT_AW, 10, full-wave index width; the ROM holds 2^(LUT_AW-2) quarter-wave entries. Requires PHASE_W >= LUT_AW.
- DATA_W, 12, per-channel sample width.
- SIGNED_OUT, 0, output mode. 0 = offset-binary unsigned samples and sum; 1 = two's-complement samples and sum.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- sample_en, in, 1, start-of-round strobe; sampled only in IDLE.
- delta, in, NUM_CH*PHASE_W, packed phase increments; channel i occupies bits [i*PHASE_W +: PHASE_W].
- ch_en, in, NUM_CH, per-channel enable.
- ovr_clr, in, 1, synchronous clear of overrun.
- sind_sum, out, DATA_W+clog2(NUM_CH), composite sum; holds between rounds.
- sum_valid, out, 1, one-cycle pulse when sind_sum updates.
- busy, out, 1, high while a round is in progress.
- overrun, out, 1, sticky flag: sample_en arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - All phase accumulators, sind_sum, sum_valid, busy and overrun go to 0; FSM goes to IDLE.
  - Reset mid-round aborts the round; no sum_valid is produced.
- Index and sample:
  - idx = phase[PHASE_W-1 -: LUT_AW].
  - Quarter-wave folding uses idx[LUT_AW-1:LUT_AW-2]: quadrant 1 mirrors the address; quadrants 2/3 negate.
  - A = 2^(DATA_W-1)-1. Signed sample = round(A*sin(2*pi*idx/2^LUT_AW)). Unsigned sample = signed sample + 2^(DATA_W-1).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: when sample_en=1 at edge E0, latch delta and ch_en, clear the accumulator, ch=0, go to RUN.
  - RUN: one channel per cycle. Issue the LUT address for ch, then phase[ch] += delta[ch] modulo 2^PHASE_W; stay in RUN until ch = NUM_CH-1, then go to DRAIN.
  - DRAIN: last LUT read completes; accumulate; go to DONE.
  - DONE: register sind_sum and pulse sum_valid; return to IDLE.
- Timing:
  - The LUT is a registered ROM with 1-cycle read latency; folding and accumulation occur in the following cycle.
  - sum_valid is high for exactly the one cycle following edge E0+NUM_CH+2.
  - busy is high from E0+1 through E0+NUM_CH+2 and is low in the sum_valid cycle, so back-to-back rounds are legal.
  - A round uses the pre-increment phase, so the first round after reset samples idx=0.
- Disabled channel (ch_en=0 at latch): contributes 0 to the sum and its phase accumulator holds.
- Arithmetic:
  - The accumulator is DATA_W+clog2(NUM_CH) bits (min 1 extra bit when NUM_CH=1) and cannot overflow.
  - It is sign-extended in signed mode and zero-extended in unsigned mode.
- delta and ch_en changes during RUN have no effect until the next round.
- overrun:
  - Set when sample_en=1 while busy=1; the request is dropped.
  - ovr_clr clears it. If set and clear occur in the same cycle, set wins.

Decomposition:
- Package sine_pkg holds:
  - FSM state typedef (IDLE/RUN/DRAIN/DONE);
  - clog2 constant function;
  - quarter-wave ROM init helper/constants (amplitude, offset).
- Sub-module sine_quarter_lut (params LUT_AW, DATA_W, SIGNED_OUT):
  - inputs clk, rst, idx; output registered folded sample;
  - contains the quarter-wave ROM and quadrant logic.
- The top level holds the FSM, phase accumulator array, accumulator and flags.

Test Plan:
- Reset then sample_en pulse, NUM_CH=2, delta={0,0}, both enabled, unsigned → sum_valid exactly 4 cycles after the sampling edge; sind_sum=4096; busy high 4 cycles.
- delta0=1024, ch_en=01, unsigned, four rounds → sind_sum sequence 2048, 4095, 2048, 1, then 2048 again on the fifth round (wrap-around).
- Same as previous with SIGNED_OUT=1 → 0, 2047, 0, -2047 (13-bit two's complement).
- sample_en held high continuously → rounds every 5 cycles (busy+valid); sample_en seen during busy sets overrun; ovr_clr clears it; set+clear in the same cycle leaves overrun=1.
- Change delta and ch_en mid-RUN → current round's sum unaffected; the change takes effect next round; a disabled channel's phase holds (verify on re-enable).
- Assert rst mid-RUN → outputs zero immediately, no sum_valid; the next round starts again from idx=0 (sum 4096 with delta=0).
